// File: rtl/fifo_drain_ctrl_pkg.sv
// Shared definitions for the FIFO drain controller: FSM encoding, lane/counter widths.
// Latency: none (types and constants only).
// Backpressure: n/a.
package fifo_drain_ctrl_pkg;

    // Word counters (issued / accepted) and the num_words port share this width.
    localparam int CNT_W = 5;

    // Each FIFO lane is a double-width element (products/accumulators of DATA_WIDTH inputs).
    localparam int LANE_FACTOR = 2;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_DRAIN = 3'd2,
        S_FLUSH = 3'd3,
        S_FIN   = 3'd4
    } state_e;

    // Lane width in bits for a given element width.
    function automatic int lane_width(input int data_width);
        return data_width * LANE_FACTOR;
    endfunction

    // Requested word count forced into 1..max_n.
    function automatic logic [CNT_W-1:0] clamp_words(input logic [CNT_W-1:0] n,
                                                     input logic [CNT_W-1:0] max_n);
        if (n == '0) begin
            return CNT_W'(1);
        end else if (n > max_n) begin
            return max_n;
        end else begin
            return n;
        end
    endfunction

endpackage

// File: rtl/fifo_drain_ctrl_if.sv
// Bundle of control, FIFO-array and downstream stream signals for fifo_drain_ctrl.
// Latency: none (wires only).
// Backpressure: m_ready from the sink throttles m_valid/m_data from the controller.
interface fifo_drain_ctrl_if
    import fifo_drain_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int SYSTOLIC_SIZE = 16
);
    localparam int W = SYSTOLIC_SIZE / 2 * lane_width(DATA_WIDTH);

    logic             start;
    logic [CNT_W-1:0] num_words;
    logic             fifo_rd_en;
    logic             fifo_rd_clr;
    logic [W-1:0]     fifo_data;
    logic             m_valid;
    logic             m_ready;
    logic [W-1:0]     m_data;
    logic             busy;
    logic             done;

    // Controller side.
    modport slave (
        input  start, num_words, fifo_data, m_ready,
        output fifo_rd_en, fifo_rd_clr, m_valid, m_data, busy, done
    );

    // Requester / FIFO array / sink side.
    modport master (
        output start, num_words, fifo_data, m_ready,
        input  fifo_rd_en, fifo_rd_clr, m_valid, m_data, busy, done
    );

endinterface

// File: rtl/fifo_drain_ctrl_skid_buf2.sv
// Two-entry in-order skid buffer; head word presented on head_dat when head_vld.
// Latency: a pushed word is visible at the head the cycle after the push (when empty).
// Backpressure: none internally; the writer must not push when full unless popping.
module skid_buf2 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] head_dat,
    output logic             head_vld,
    output logic [1:0]       occ
);

    logic [WIDTH-1:0] slot0_q, slot0_d;
    logic [WIDTH-1:0] slot1_q, slot1_d;
    logic [1:0]       cnt_q, cnt_d;

    // Storage and occupancy registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot0_q <= '0;
            slot1_q <= '0;
            cnt_q   <= '0;
        end else begin
            slot0_q <= slot0_d;
            slot1_q <= slot1_d;
            cnt_q   <= cnt_d;
        end
    end

    // slot0 is always the oldest word; a simultaneous push/pop shifts and refills.
    always_comb begin
        slot0_d = slot0_q;
        slot1_d = slot1_q;
        cnt_d   = cnt_q;
        unique case ({push, pop})
            2'b10: begin
                if (cnt_q == 2'd0) begin
                    slot0_d = push_dat;
                end else begin
                    slot1_d = push_dat;
                end
                cnt_d = cnt_q + 2'd1;
            end
            2'b01: begin
                slot0_d = slot1_q;
                cnt_d   = cnt_q - 2'd1;
            end
            2'b11: begin
                if (cnt_q == 2'd2) begin
                    slot0_d = slot1_q;
                    slot1_d = push_dat;
                end else begin
                    slot0_d = push_dat;
                end
            end
            default: begin
            end
        endcase
    end

    assign head_dat = slot0_q;
    assign head_vld = (cnt_q != 2'd0);
    assign occ      = cnt_q;

endmodule

// File: rtl/fifo_drain_ctrl.sv
// Drains num_words words from a FIFO array into a valid/ready stream; optional ReLU (DRAIN_RELU_EN).
// Latency: first m_valid 3 cycles after start is accepted (clear, read, capture), then 1 word/cycle.
// Backpressure: m_ready low stalls the skid buffer; reads are only issued when a slot is free for them.
module fifo_drain_ctrl
    import fifo_drain_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int SYSTOLIC_SIZE = 16,
    parameter int NUM_MODULES   = 8
) (
    input  logic             clk,
    input  logic             rst,
    fifo_drain_ctrl_if.slave bus
);

    localparam int LANE_W = lane_width(DATA_WIDTH);
    localparam int W      = SYSTOLIC_SIZE / 2 * LANE_W;
    localparam logic [CNT_W-1:0] MAX_WORDS = CNT_W'(SYSTOLIC_SIZE);
    // Lanes subject to ReLU, never more than the bus actually carries.
    localparam int RELU_LANES = (NUM_MODULES * LANE_W <= W) ? NUM_MODULES : W / LANE_W;
`ifdef DRAIN_RELU_EN
    localparam bit RELU_ON = 1'b1;
`else
    localparam bit RELU_ON = 1'b0;
`endif

    state_e           state_q, state_d;
    logic [CNT_W-1:0] issued_q, issued_d;
    logic [CNT_W-1:0] accepted_q, accepted_d;
    logic [CNT_W-1:0] num_q, num_d;
    logic             rd_inflight_q, rd_inflight_d;

    logic             rd_en;
    logic             rd_clr;
    logic             fin;
    logic             pop;
    logic             room;
    logic [2:0]       occ_after;
    logic [1:0]       skid_occ;
    logic             skid_vld;
    logic [W-1:0]     skid_head;
    logic [W-1:0]     m_data_c;

    skid_buf2 #(.WIDTH(W)) u_skid (
        .clk      (clk),
        .rst      (rst),
        .push     (rd_inflight_q),
        .push_dat (bus.fifo_data),
        .pop      (pop),
        .head_dat (skid_head),
        .head_vld (skid_vld),
        .occ      (skid_occ)
    );

    assign pop = skid_vld & bus.m_ready;

    // Occupancy once this cycle's pop and the read in flight have settled; a new
    // read may go out only if that leaves a slot for it to land in.
    always_comb begin
        occ_after = {1'b0, skid_occ} + {2'b00, rd_inflight_q} - {2'b00, pop};
        room      = (occ_after < 3'd2);
    end

    // State, counters and the one-cycle read-in-flight marker.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            issued_q      <= '0;
            accepted_q    <= '0;
            num_q         <= '0;
            rd_inflight_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            issued_q      <= issued_d;
            accepted_q    <= accepted_d;
            num_q         <= num_d;
            rd_inflight_q <= rd_inflight_d;
        end
    end

    // Next state, read strobes and counter updates.
    always_comb begin
        state_d    = state_q;
        issued_d   = issued_q;
        accepted_d = accepted_q + CNT_W'(pop);
        num_d      = num_q;
        rd_en      = 1'b0;
        rd_clr     = 1'b0;
        fin        = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    num_d      = clamp_words(bus.num_words, MAX_WORDS);
                    issued_d   = '0;
                    accepted_d = '0;
                    state_d    = S_CLEAR;
                end
            end
            S_CLEAR: begin
                rd_clr  = 1'b1;
                state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if ((issued_q < num_q) && room) begin
                    rd_en    = 1'b1;
                    issued_d = issued_q + CNT_W'(1);
                    if (issued_d == num_q) begin
                        state_d = S_FLUSH;
                    end
                end
            end
            S_FLUSH: begin
                if ((accepted_q == num_q) && (skid_occ == 2'd0) && !rd_inflight_q) begin
                    state_d = S_FIN;
                end
            end
            S_FIN: begin
                fin     = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        rd_inflight_d = rd_en;
    end

    // Optional ReLU on the skid-buffer head: negative signed lanes are zeroed.
    always_comb begin
        m_data_c = skid_head;
        for (int i = 0; i < RELU_LANES; i++) begin
            if (RELU_ON && skid_head[i*LANE_W + LANE_W - 1]) begin
                m_data_c[i*LANE_W +: LANE_W] = '0;
            end
        end
    end

    assign bus.fifo_rd_en  = rd_en;
    assign bus.fifo_rd_clr = rd_clr;
    assign bus.m_valid     = skid_vld;
    assign bus.m_data      = m_data_c;
    assign bus.busy        = (state_q != S_IDLE);
    assign bus.done        = fin;

endmodule

// File: tb/tb_fifo_drain_ctrl.sv
// Bench for fifo_drain_ctrl: FIFO-array model, queue scoreboard, directed runs.
// Latency: checks first m_valid after 3 busy cycles and done at cycle N+4 with m_ready high.
// Backpressure: drives m_ready high or with the repeating 1,0,0,1 pattern.
module tb_fifo_drain_ctrl;

`ifdef DRAIN_RELU_EN
    localparam bit RELU_ON = 1'b1;
`else
    localparam bit RELU_ON = 1'b0;
`endif
    localparam logic [127:0] POISON = {8{16'hDEAD}};

    logic clk;
    logic rst;

    fifo_drain_ctrl_if #(.DATA_WIDTH(8), .SYSTOLIC_SIZE(16)) bus ();

    fifo_drain_ctrl #(.DATA_WIDTH(8), .SYSTOLIC_SIZE(16), .NUM_MODULES(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [127:0] mem [16];
    logic [127:0] exp_q [$];
    logic [127:0] last_word;
    int           acc_cnt  = 0;
    int           done_cnt = 0;
    int           clr_cnt  = 0;
    int           ready_mode = 0;
    int           pidx = 0;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Expected downstream word: negative signed 16-bit lanes zeroed when ReLU is built in.
    function automatic logic [127:0] relu_w(input logic [127:0] w);
        logic [127:0] r;
        r = w;
        for (int j = 0; j < 8; j++) begin
            if (RELU_ON && ($signed(w[j*16 +: 16]) < 0)) r[j*16 +: 16] = 16'h0000;
        end
        return r;
    endfunction

    // Downstream ready: constant high, or 1,0,0,1 repeating.
    always @(posedge clk) begin
        #1;
        if (ready_mode == 0) begin
            bus.m_ready = 1'b1;
        end else begin
            bus.m_ready = ((pidx % 4) == 0) || ((pidx % 4) == 3);
            pidx++;
        end
    end

    // FIFO array: read pointer cleared by fifo_rd_clr, data valid the cycle after fifo_rd_en.
    int  fptr;
    bit  fpend;
    int  fpend_idx;
    always @(negedge clk) begin
        if (rst) begin
            fptr = 0;
            fpend = 1'b0;
            bus.fifo_data = POISON;
        end else begin
            bus.fifo_data = fpend ? mem[fpend_idx] : POISON;
            fpend = bus.fifo_rd_en;
            fpend_idx = fptr % 16;
            if (bus.fifo_rd_clr) fptr = 0;
            if (bus.fifo_rd_en) fptr = fptr + 1;
        end
    end

    // Scoreboard: word order/content, stall stability, skid room at every read, valid vs occupancy.
    int           issued_m = 0;
    int           acc_m = 0;
    int           infl_m = 0;
    bit           prev_stall = 1'b0;
    logic [127:0] prev_data;
    always @(negedge clk) begin
        int occ;
        bit pop;
        if (rst) begin
            issued_m = 0; acc_m = 0; infl_m = 0; prev_stall = 1'b0;
            exp_q.delete();
        end else begin
            pop = bus.m_valid && bus.m_ready;
            occ = issued_m - infl_m - acc_m;
            chk("m_valid_vs_occupancy", bus.m_valid, occ > 0);
            if (prev_stall) chk("stall_hold", bus.m_data, prev_data);
            if (bus.fifo_rd_en) chk("rd_room", (occ + infl_m - int'(pop)) <= 1, 1'b1);
            if (pop) begin
                if (exp_q.size() == 0) chk("extra_word", 1'b1, 1'b0);
                else chk("word", bus.m_data, exp_q.pop_front());
                last_word = bus.m_data;
                acc_cnt++;
                acc_m++;
            end
            if (bus.done) done_cnt++;
            if (bus.fifo_rd_clr) clr_cnt++;
            prev_stall = bus.m_valid && !bus.m_ready;
            prev_data  = bus.m_data;
            if (bus.fifo_rd_en) issued_m++;
            infl_m = bus.fifo_rd_en ? 1 : 0;
        end
    end

    task automatic run(input logic [4:0] nw, input int mode, input bit pulse_again);
        int n, cyc, lat, acc0, d0, c0;
        n = (nw == 0) ? 1 : ((nw > 16) ? 16 : int'(nw));
        @(negedge clk);
        ready_mode = mode;
        pidx = 0;
        for (int k = 0; k < n; k++) exp_q.push_back(relu_w(mem[k]));
        acc0 = acc_cnt; d0 = done_cnt; c0 = clr_cnt;
        bus.start = 1'b1;
        bus.num_words = nw;
        cyc = 0;
        lat = -1;
        while (cyc < 200) begin
            @(negedge clk);
            bus.start = pulse_again && (cyc == 4);
            if (pulse_again && (cyc == 4)) bus.num_words = 5'd2;
            if (cyc == 0) begin
                chk("clear_cycle_rd_clr", bus.fifo_rd_clr, 1'b1);
                chk("clear_cycle_busy", bus.busy, 1'b1);
            end
            if (bus.m_valid && (lat < 0)) lat = cyc;
            if (bus.done) break;
            cyc++;
        end
        bus.start = 1'b0;
        if (cyc >= 200) chk("done_timeout", 1'b0, 1'b1);
        chk("first_valid_latency", lat, 3);
        if (mode == 0) chk("done_cycle", cyc, n + 4);
        repeat (3) @(negedge clk);
        #2;
        chk("words_delivered", acc_cnt - acc0, n);
        chk("done_pulses", done_cnt - d0, 1);
        chk("rd_clr_pulses", clr_cnt - c0, 1);
        chk("queue_empty", exp_q.size(), 0);
        chk("idle_after", bus.busy, 1'b0);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_rd_en"},  bus.fifo_rd_en, 1'b0);
        chk({tag, "_rd_clr"}, bus.fifo_rd_clr, 1'b0);
        chk({tag, "_m_valid"}, bus.m_valid, 1'b0);
        chk({tag, "_busy"},   bus.busy, 1'b0);
        chk({tag, "_done"},   bus.done, 1'b0);
        chk({tag, "_m_data"}, bus.m_data, 128'h0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int k, acc0;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.num_words = 5'd0;
        bus.m_ready = 1'b1;
        for (int w = 0; w < 16; w++)
            for (int j = 0; j < 8; j++)
                mem[w][j*16 +: 16] = 16'((w << 12) | (j << 8) | (w * 8 + j));
        #3;
        chk_outputs_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        run(5'd16, 0, 1'b0);   // full drain, ready high
        run(5'd16, 1, 1'b0);   // ready 1,0,0,1
        run(5'd0,  0, 1'b0);   // clamps to 1
        run(5'd20, 0, 1'b0);   // clamps to 16
        run(5'd8,  0, 1'b1);   // stray start mid-drain ignored

        mem[0][15:0]  = 16'hFF80;
        mem[0][31:16] = 16'h007F;
        run(5'd1, 0, 1'b0);
        chk("relu_neg_lane", last_word[15:0], RELU_ON ? 16'h0000 : 16'hFF80);
        chk("relu_pos_lane", last_word[31:16], 16'h007F);

        // Reset after 5 words accepted, then a clean 3-word drain.
        @(negedge clk);
        ready_mode = 0;
        for (int w = 0; w < 16; w++) exp_q.push_back(relu_w(mem[w]));
        acc0 = acc_cnt;
        bus.start = 1'b1;
        bus.num_words = 5'd16;
        @(negedge clk);
        bus.start = 1'b0;
        k = 0;
        while (((acc_cnt - acc0) < 5) && (k < 100)) begin
            @(negedge clk);
            #2;
            k++;
        end
        chk("five_accepted_before_rst", acc_cnt - acc0, 5);
        chk("valid_before_rst", bus.m_valid, 1'b1);
        rst = 1'b1;
        #1;
        chk_outputs_zero("midrst");
        repeat (2) @(negedge clk);
        #2;
        rst = 1'b0;
        run(5'd3, 0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
